// File: rtl/rd_addr_gen.sv
// rd_addr_gen: read-side burst engine for the DDR bandwidth test.
// Issues fixed-length AXI4 INCR read bursts with a bounded number in flight,
// forwards returned beats through a one-entry output stage, and flags
// burst-framing and response errors.
module rd_addr_gen #(
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LENGTH    = 15,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [63:0]           cfg,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           byte_cnt,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES = (BURST_LENGTH + 1) * BEAT_BYTES;
  localparam logic [31:0] BURST_INC   = 32'(BURST_BYTES);
  localparam logic [31:0] BEAT_INC    = 32'(BEAT_BYTES);
  localparam logic [31:0] ALIGN_MASK  = ~(BURST_INC - 32'd1);
  localparam logic [3:0]  MAX_OUT     = 4'(MAX_OUTSTANDING);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [17:0] ar_rem;
  logic [17:0] ar_rem_nxt;
  logic [3:0]  outstanding;
  logic [3:0]  out_nxt;
  logic [7:0]  beat;
  logic        err_q;
  logic [31:0] byte_cnt_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  logic        start_acc;
  logic [17:0] cfg_cnt;
  logic        ar_hs;
  logic        r_hs;
  logic        rl_hs;
  logic        frame_err;
  logic        cfg_unused;

  assign cfg_cnt    = cfg[56:39];
  assign cfg_unused = ^{cfg[63:57], cfg[38:32]};
  assign start_acc  = start && (state == S_IDLE);
  assign ar_hs      = arvalid_q && arready;
  assign r_hs       = rvalid && rready;
  assign rl_hs      = r_hs && rlast;
  assign rready     = !out_valid || dout_ready;
  assign ar_rem_nxt = ar_hs ? (ar_rem - 18'd1) : ar_rem;

  assign frame_err = r_hs && ((rlast && (beat != LAST_BEAT)) ||
                              (!rlast && (beat == LAST_BEAT)) ||
                              (rresp != 2'b00) ||
                              (outstanding == 4'd0));

  assign arlen      = LAST_BEAT;
  assign arsize     = 3'($clog2(BEAT_BYTES));
  assign arburst    = 2'b01;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign err        = err_q;
  assign byte_cnt   = byte_cnt_q;
  assign dout_data  = out_data;
  assign dout_valid = out_valid;

  // Outstanding count after this cycle's AR and final-R handshakes
  always_comb begin
    out_nxt = outstanding;
    if (ar_hs && !rl_hs) begin
      out_nxt = outstanding + 4'd1;
    end else if (!ar_hs && rl_hs && (outstanding != 4'd0)) begin
      out_nxt = outstanding - 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_acc) state_nxt = (cfg_cnt == 18'd0) ? S_DONE : S_RUN;
      S_RUN:  if ((ar_rem == 18'd0) && (outstanding == 4'd0) && !out_valid) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Address channel: latch on start, hold while stalled, advance per handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      ar_rem    <= '0;
    end else begin
      if (start_acc) begin
        araddr_q  <= cfg[31:0] & ALIGN_MASK;
        ar_rem    <= cfg_cnt;
        arvalid_q <= (cfg_cnt != 18'd0);
      end else begin
        if (ar_hs) begin
          araddr_q <= araddr_q + BURST_INC;
          ar_rem   <= ar_rem_nxt;
        end
        // arvalid re-evaluated only when not stalled, so it stays up until arready
        if (state != S_RUN) begin
          arvalid_q <= 1'b0;
        end else if (!(arvalid_q && !arready)) begin
          arvalid_q <= (ar_rem_nxt != 18'd0) && (out_nxt < MAX_OUT);
        end
      end
    end
  end

  // In-flight burst counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) outstanding <= '0;
    else       outstanding <= out_nxt;
  end

  // Beat position within the current burst; rlast always closes a burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat <= '0;
    end else if (r_hs) begin
      beat <= rlast ? 8'd0 : (beat + 8'd1);
    end
  end

  // One-entry output register between R channel and downstream consumer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (r_hs) begin
      out_valid <= 1'b1;
      out_data  <= rdata;
    end else if (dout_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error and received-byte counter, both cleared by an accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q      <= 1'b0;
      byte_cnt_q <= '0;
    end else if (start_acc) begin
      err_q      <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      if (frame_err) err_q <= 1'b1;
      if (r_hs)      byte_cnt_q <= byte_cnt_q + BEAT_INC;
    end
  end

endmodule

// File: tb/tb_rd_addr_gen.sv
// tb_rd_addr_gen: table-driven bench for rd_addr_gen with a behavioural
// AXI read slave and a dout scoreboard.
module tb_rd_addr_gen;

  localparam int DW = 64;
  localparam int BL = 15;
  localparam int MO = 4;

  logic          clk;
  logic          rstn;
  logic [63:0]   cfg;
  logic          start;
  logic          busy, done, err;
  logic [31:0]   byte_cnt, araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] dout_data;
  logic          dout_valid, dout_ready;

  rd_addr_gen #(.DATA_WIDTH(DW), .BURST_LENGTH(BL), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rstn(rstn), .cfg(cfg), .start(start),
    .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    int          count;
    int          dmode;     // 1: random dout_ready
    int          armode;    // 1: random arready
    int          delay;     // cycles before the slave may return data
    int          fault;     // burst index that ends early (rlast on beat 14), -1 none
    int          resp;      // burst index with SLVERR on beat 3, -1 none
    int          restart;   // cycle offset of an extra start while busy, 0 none
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_beats;
    logic        exp_err;
    int          exp_arbr;  // ARs issued before first R, -1 unchecked
  } vec_t;

  vec_t vecs[9];

  int pass_cnt;
  int total_cnt;

  // Run controls (written by the main sequence only)
  int          m_dmode, m_armode, m_delay, m_fault, m_resp, run_id;
  logic [31:0] run_base;

  // Slave / scoreboard state (written by the cycle process only)
  int          last_id, seq, r_hold, cur_beat, outst;
  int          done_cnt, beats_out, r_cnt, ar_cnt, bursts_done;
  int          addr_err, data_err, rr_err, hold_err, max_out, ar_before_r;
  logic [31:0] first_addr, last_addr, prev_addr;
  logic        prev_stall;
  logic [DW-1:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // AXI read slave, output scoreboard and protocol monitors.
  // Inputs change at negedge; handshakes are evaluated 1 ns later.
  initial begin
    last_id = -1;
    seq = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn || run_id != last_id) begin
        last_id = run_id;
        r_hold = m_delay; cur_beat = 0; outst = 0;
        done_cnt = 0; beats_out = 0; r_cnt = 0; ar_cnt = 0; bursts_done = 0;
        addr_err = 0; data_err = 0; rr_err = 0; hold_err = 0; max_out = 0; ar_before_r = -1;
        first_addr = '0; last_addr = '0; prev_addr = '0; prev_stall = 1'b0;
        sb.delete();
      end
      arready    = (m_armode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = (m_dmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid     = (outst > 0) && (r_hold == 0);
      rdata      = {32'(seq) ^ 32'hC0DE_0000, ~32'(seq)};
      rlast      = (cur_beat == BL) || (bursts_done == m_fault && cur_beat == 14);
      rresp      = (bursts_done == m_resp && cur_beat == 3) ? 2'b10 : 2'b00;
      #1;
      if (!rstn) continue;
      if (r_hold > 0) r_hold--;
      if (prev_stall && (!arvalid || araddr !== prev_addr)) hold_err++;
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
      if (rready !== (!dout_valid || dout_ready)) rr_err++;
      if (done) done_cnt++;
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) data_err++;
        else begin
          if (dout_data !== sb[0]) data_err++;
          void'(sb.pop_front());
        end
        beats_out++;
      end
      if (rvalid && rready) begin
        if (r_cnt == 0) ar_before_r = ar_cnt;
        r_cnt++;
        sb.push_back(rdata);
        seq++;
        if (rlast) begin
          cur_beat = 0; bursts_done++; outst--;
        end else begin
          cur_beat++;
        end
      end
      if (arvalid && arready) begin
        if (araddr !== ((run_base & ~32'h7F) + 32'(ar_cnt) * 32'd128)) addr_err++;
        if (ar_cnt == 0) first_addr = araddr;
        last_addr = araddr;
        ar_cnt++;
        outst++;
      end
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic seen;
    run_base = v.base;
    m_dmode = v.dmode; m_armode = v.armode; m_delay = v.delay;
    m_fault = v.fault; m_resp = v.resp;
    run_id++;
    repeat (2) @(negedge clk);
    cfg   = {7'h55, 18'(v.count), 7'h2A, v.base};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg   = '0;
    #2;
    check($sformatf("v%0d busy_n1", idx), busy, (v.count != 0));
    check($sformatf("v%0d arvalid_n1", idx), arvalid, (v.count != 0));
    check($sformatf("v%0d done_n1", idx), done, (v.count == 0));
    check($sformatf("v%0d err_cleared", idx), err, 0);
    seen = done;
    for (int c = 1; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (v.restart != 0 && c == v.restart) begin
        cfg = {7'h00, 18'd7, 7'h00, 32'h7777_0000};
        start = 1'b1;
      end else begin
        start = 1'b0;
        cfg = '0;
      end
      #2;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check($sformatf("v%0d done_seen", idx), seen, 1);
    check($sformatf("v%0d byte_cnt", idx), byte_cnt, 32'(v.exp_beats * 8));
    check($sformatf("v%0d err_at_done", idx), err, v.exp_err);
    check($sformatf("v%0d busy_at_done", idx), busy, 0);
    repeat (3) @(negedge clk);
    #2;
    check($sformatf("v%0d done_once", idx), done_cnt, 1);
    check($sformatf("v%0d err_sticky", idx), err, v.exp_err);
    check($sformatf("v%0d beats", idx), beats_out, v.exp_beats);
    check($sformatf("v%0d ar_count", idx), ar_cnt, v.count);
    check($sformatf("v%0d addr_err", idx), addr_err, 0);
    check($sformatf("v%0d data_err", idx), data_err, 0);
    check($sformatf("v%0d rready_err", idx), rr_err, 0);
    check($sformatf("v%0d ar_hold_err", idx), hold_err, 0);
    check($sformatf("v%0d max_out_le", idx), (max_out <= MO), 1);
    if (v.count > 0) begin
      check($sformatf("v%0d first_araddr", idx), first_addr, v.exp_first);
      check($sformatf("v%0d last_araddr", idx), last_addr, v.exp_last);
    end
    if (v.exp_arbr >= 0) check($sformatf("v%0d ar_before_r", idx), ar_before_r, v.exp_arbr);
  endtask

  task automatic reset_mid_run();
    logic reached;
    run_base = 32'h2000_0000;
    m_dmode = 0; m_armode = 0; m_delay = 0; m_fault = -1; m_resp = -1;
    run_id++;
    repeat (2) @(negedge clk);
    cfg   = {7'h00, 18'd5, 7'h00, 32'h2000_0000};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      #2;
      if (bursts_done >= 2) reached = 1'b1;
    end
    check("rst two_bursts_reached", reached, 1);
    check("rst no_done_before", done_cnt, 0);
    check("rst busy_before", busy, 1);
    #1 rstn = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst arvalid", arvalid, 0);
    check("rst dout_valid", dout_valid, 0);
    check("rst araddr", araddr, 0);
    check("rst byte_cnt", byte_cnt, 0);
    check("rst rready", rready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #2;
    check("rst done_after_release", done, 0);
    check("rst busy_after_release", busy, 0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    m_dmode = 0; m_armode = 0; m_delay = 0; m_fault = -1; m_resp = -1;
    run_id = 0; run_base = '0;
    start = 1'b0; cfg = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset arvalid", arvalid, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset araddr", araddr, 0);
    check("reset byte_cnt", byte_cnt, 0);
    check("reset rready", rready, 1);
    check("const arlen", arlen, 8'd15);
    check("const arsize", arsize, 3'd3);
    check("const arburst", arburst, 2'b01);
    rstn = 1'b1;

    //          base            cnt dm am dly flt rsp rst  first           last            beats err  arbr
    vecs[0] = '{32'h1000_0000,  3,  0, 0, 0,  -1, -1, 0,  32'h1000_0000, 32'h1000_0100, 48,  1'b0, -1};
    vecs[1] = '{32'h2000_0040,  10, 0, 0, 50, -1, -1, 0,  32'h2000_0000, 32'h2000_0480, 160, 1'b0, 4};
    vecs[2] = '{32'h0300_0000,  6,  1, 1, 0,  -1, -1, 0,  32'h0300_0000, 32'h0300_0280, 96,  1'b0, -1};
    vecs[3] = '{32'h4000_0000,  4,  0, 0, 0,  1,  -1, 0,  32'h4000_0000, 32'h4000_0180, 63,  1'b1, -1};
    vecs[4] = '{32'h4000_1000,  1,  0, 0, 0,  -1, -1, 0,  32'h4000_1000, 32'h4000_1000, 16,  1'b0, -1};
    vecs[5] = '{32'h5000_0000,  0,  0, 0, 0,  -1, -1, 0,  32'h0000_0000, 32'h0000_0000, 0,   1'b0, -1};
    vecs[6] = '{32'hFFFF_FFC0,  2,  0, 0, 0,  -1, -1, 0,  32'hFFFF_FF80, 32'h0000_0000, 32,  1'b0, -1};
    vecs[7] = '{32'h6000_0000,  2,  0, 0, 0,  -1, -1, 5,  32'h6000_0000, 32'h6000_0080, 32,  1'b0, -1};
    vecs[8] = '{32'h7000_0000,  2,  1, 0, 0,  -1, 0,  0,  32'h7000_0000, 32'h7000_0080, 32,  1'b1, -1};

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    reset_mid_run();
    run_vec(vecs[0], 9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rd_addr_gen.md
# rd_addr_gen

Read-side burst engine for the DDR bandwidth test: the counterpart of the write-side address generator. On `start` it latches a base address and burst count from `cfg`, issues fixed-length AXI4 INCR read bursts with a bounded number outstanding, passes returned beats to the downstream consumer, and checks burst framing. It sits between the test controller (cfg/start/done) and the AXI HP read port (AR/R channels).

## Interface
- `DATA_WIDTH`, 64: AXI data width in bits.
- `BURST_LENGTH`, 15: AXI `arlen` value; beats per burst = `BURST_LENGTH`+1.
- `MAX_OUTSTANDING`, 4: maximum in-flight read bursts, 1..15.
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous active-low reset.
- `cfg`  in  64  [31:0] base byte address, [56:39] burst count (18 bits); other bits ignored.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when every requested burst has fully returned.
- `err`  out  1  sticky framing/response error; cleared by an accepted `start`.
- `byte_cnt`  out  32  bytes received since the last accepted `start`.
- `araddr`  out  32; `arlen` out 8 (=`BURST_LENGTH`); `arsize` out 3 (=log2(`DATA_WIDTH`/8)); `arburst` out 2 (=2'b01); `arvalid` out 1; `arready` in 1.
- `rdata` in `DATA_WIDTH`; `rresp` in 2; `rlast` in 1; `rvalid` in 1; `rready` out 1.
- `dout_data`  out  `DATA_WIDTH`; `dout_valid` out 1; `dout_ready` in 1: downstream beat stream.

## Operation
- BYTES_PER_BURST = (`BURST_LENGTH`+1)·`DATA_WIDTH`/8 (128 at defaults). Latched address has its low log2(BYTES_PER_BURST) bits forced to 0.
- States:
  - IDLE: `start` latches address and burst count. Count 0 → DONE; otherwise → RUN.
  - RUN: issue bursts and collect beats. → DONE when AR-remaining = 0, outstanding = 0, and no beat is in the output register.
  - DONE: one cycle, `done`=1, then → IDLE.
- AR issue: `arvalid` = (AR-remaining > 0) && (outstanding < `MAX_OUTSTANDING`), in RUN only. `araddr`/`arvalid` are registered and held stable until `arready`. On each handshake, `araddr` += BYTES_PER_BURST (32-bit wrap, no 4 KB check) and AR-remaining decrements.
- Outstanding counter: +1 on AR handshake, −1 on R handshake with `rlast`. Both in the same cycle leaves it unchanged. Never exceeds `MAX_OUTSTANDING`.
- R path is a one-entry registered output stage:
  - `rready` = !out_valid || `dout_ready`.
  - On R handshake, `rdata` → `dout_data` and `dout_valid`=1.
  - `dout_valid` drops after a `dout_ready` cycle with no new beat.
- Beat counter (0..`BURST_LENGTH`) advances per R handshake and resets to 0 on `rlast`.
- `err` sets on any of:
  - `rlast`=1 with beat ≠ `BURST_LENGTH`;
  - `rlast`=0 with beat = `BURST_LENGTH`;
  - `rresp` ≠ 0;
  - R handshake while outstanding = 0.
- Errors never stop the engine. A burst ends only on `rlast`.
- `byte_cnt` += `DATA_WIDTH`/8 per R handshake.
- `start` outside IDLE is ignored; latched values and counters are unchanged.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `arvalid`, `dout_valid` = 0; `araddr`, `byte_cnt`, all counters = 0; `rready` = 1.
- `start` sampled at edge N → `busy`=1 and `arvalid`=1 at N+1 (count > 0). With count = 0: `done` at N+1, `busy` stays 0.
- AR-to-AR spacing: 1 cycle while `arready`=1 and credit is available.
- R-to-dout latency: 1 cycle. Full throughput is 1 beat/cycle when `dout_ready`=1.
- Final `rlast` handshake at edge M → `dout_valid` at M+1. When that beat drains, `done` pulses the following cycle and `busy` falls with it.
- Asynchronous reset mid-run returns to the reset values immediately. In-flight AXI beats after reset are the bench's responsibility: slave is reset together.

## Test plan
- Basic run: cfg addr=0x1000_0000, count=3, slave always ready → araddr 0x1000_0000/0x1000_0080/0x1000_0100, 48 beats on dout, byte_cnt=384, `done` pulses once, err=0.
- Credit limit: MAX_OUTSTANDING=4, count=10, slave delays first R by 50 cycles → exactly 4 ARs issued before any R; outstanding never >4; total 160 beats.
- Backpressure: `dout_ready` toggling 1/0 randomly → no beat lost or duplicated; dout_data order matches rdata order; `rready` low only while the output stage is full and `dout_ready`=0.
- Framing error: slave asserts `rlast` on beat 14 of burst 2 → err=1 sticky, run completes with `done`; next `start` clears err.
- Edge cases: count=0 → `done` at N+1 with no AR. cfg addr=0xFFFF_FFC0 with count=2 → second araddr=0x0000_0000 (low 7 bits masked first: 0xFFFF_FF80, then wrap). `start` while busy → ignored.
- Reset mid-run after 2 of 5 bursts → all outputs return to reset values, `done` never asserted, and a fresh `start` runs correctly.
